// File: rtl/arima_pkg.sv
// Shared types and limits for the ARIMA differencing sequencer.
package arima_pkg;

    localparam int unsigned DIFF_MAX_ORDER = 9;
    localparam int unsigned DIFF_ORDER_W   = 4;
    localparam int unsigned DIFF_DATA_W    = 32;
    localparam int unsigned DIFF_LEN_W     = 32;

    // Mode word understood by the differencing stage.
    typedef enum logic [1:0] {
        DIFF_WORK  = 2'b00,
        DIFF_STALL = 2'b01,
        DIFF_INIT  = 2'b10,
        DIFF_CLEAR = 2'b11
    } diff_mode_e;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_CLEAR = 3'd1,
        SEQ_RUN   = 3'd2,
        SEQ_FLUSH = 3'd3,
        SEQ_DONE  = 3'd4
    } diff_seq_state_e;

endpackage

// File: rtl/diff_sequencer_if.sv
// Control, sample-in and difference-out streams of the differencing sequencer.
interface diff_sequencer_if
    import arima_pkg::*;
#(
    parameter int unsigned DATA_W = DIFF_DATA_W,
    parameter int unsigned LEN_W  = DIFF_LEN_W
) ();

    logic                    start;
    logic                    abort;
    logic [DIFF_ORDER_W-1:0] cfg_order;
    logic [LEN_W-1:0]        cfg_len;

    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_W-1:0]       s_data;

    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_W-1:0]       m_data;

    logic                    snap;
    logic                    busy;
    logic                    done;
    logic                    cfg_err;

    // Frame controller / source / sink side.
    modport master (
        output start, abort, cfg_order, cfg_len, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, snap, busy, done, cfg_err
    );

    // Sequencer side.
    modport slave (
        input  start, abort, cfg_order, cfg_len, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, snap, busy, done, cfg_err
    );

endinterface

// File: rtl/diff_sequencer.sv
// Drives the d-th order differencing stage: clears it per frame, steps it once
// per accepted sample, hides warm-up samples and flags when its bank is full.
module diff_sequencer
    import arima_pkg::*;
#(
    parameter int unsigned DATA_W    = DIFF_DATA_W,
    parameter int unsigned MAX_ORDER = DIFF_MAX_ORDER,
    parameter int unsigned LEN_W     = DIFF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    diff_sequencer_if.slave   bus,
    output logic [1:0]        diff_mode,
    output logic [31:0]       diff_order,
    output logic [DATA_W-1:0] diff_data_in,
    input  logic [DATA_W-1:0] diff_data_out
);

    localparam logic [DIFF_ORDER_W-1:0] MAX_ORDER_L = DIFF_ORDER_W'(MAX_ORDER);

    diff_seq_state_e         state_q;
    logic [LEN_W-1:0]        idx_q;
    logic [DIFF_ORDER_W-1:0] order_q;
    logic [LEN_W-1:0]        len_q;
    logic                    m_valid_q;
    logic                    snap_q;
    logic                    done_q;
    logic                    cfg_err_q;

    diff_mode_e              mode_c;
    logic                    s_ready_c;
    logic                    accept_c;
    logic [LEN_W-1:0]        order_ext;

    assign order_ext = LEN_W'(order_q);

    // Stage mode and input readiness; abort forces a clear and blocks input.
    always_comb begin
        mode_c    = DIFF_STALL;
        s_ready_c = 1'b0;
        accept_c  = 1'b0;
        if (bus.abort) begin
            mode_c = DIFF_CLEAR;
        end else begin
            case (state_q)
                SEQ_CLEAR: mode_c = DIFF_CLEAR;
                SEQ_RUN: begin
                    s_ready_c = !m_valid_q || bus.m_ready;
                    accept_c  = bus.s_valid && s_ready_c;
                    if (accept_c) begin
                        mode_c = DIFF_WORK;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame FSM, sample index and registered handshake/status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            idx_q     <= '0;
            order_q   <= '0;
            len_q     <= '0;
            m_valid_q <= 1'b0;
            snap_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            snap_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.abort) begin
                if (state_q != SEQ_IDLE) begin
                    state_q   <= SEQ_IDLE;
                    m_valid_q <= 1'b0;
                    idx_q     <= '0;
                end
            end else begin
                case (state_q)
                    SEQ_IDLE: begin
                        if (bus.start) begin
                            if (bus.cfg_order > MAX_ORDER_L) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                cfg_err_q <= 1'b0;
                                order_q   <= bus.cfg_order;
                                len_q     <= bus.cfg_len;
                                state_q   <= SEQ_CLEAR;
                            end
                        end
                    end
                    SEQ_CLEAR: begin
                        idx_q <= '0;
                        if (len_q != '0) begin
                            state_q <= SEQ_RUN;
                        end else begin
                            state_q <= SEQ_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    SEQ_RUN: begin
                        if (accept_c) begin
                            // Warm-up samples only prime the stage bank.
                            m_valid_q <= (idx_q >= order_ext);
                            snap_q    <= (order_q != '0) && (idx_q == order_ext - LEN_W'(1));
                            if (idx_q < len_q) begin
                                idx_q <= idx_q + LEN_W'(1);
                            end
                            if (idx_q == len_q - LEN_W'(1)) begin
                                state_q <= SEQ_FLUSH;
                            end
                        end else if (bus.m_ready) begin
                            m_valid_q <= 1'b0;
                        end
                    end
                    SEQ_FLUSH: begin
                        if (!m_valid_q || bus.m_ready) begin
                            m_valid_q <= 1'b0;
                            state_q   <= SEQ_DONE;
                            done_q    <= 1'b1;
                        end
                    end
                    SEQ_DONE: state_q <= SEQ_IDLE;
                    default:  state_q <= SEQ_IDLE;
                endcase
            end
        end
    end

    assign bus.s_ready   = s_ready_c;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = diff_data_out;
    assign bus.snap      = snap_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.busy      = (state_q != SEQ_IDLE);

    assign diff_mode     = mode_c;
    assign diff_order    = 32'(order_q);
    assign diff_data_in  = bus.s_data;

endmodule

// File: tb/tb_diff_sequencer.sv
// Bench for diff_sequencer: a behavioural differencing stage, a table of
// directed frames, hand-built abort/config/reset sequences and random frames
// scored against a binomial-sum reference.
module tb_diff_sequencer;
    import arima_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 32;
    localparam int          NV = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    diff_mode;
    logic [31:0]   diff_order;
    logic [DW-1:0] diff_data_in;
    logic [DW-1:0] diff_data_out;

    diff_sequencer_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

    diff_sequencer #(.DATA_W(DW), .MAX_ORDER(DIFF_MAX_ORDER), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .diff_mode     (diff_mode),
        .diff_order    (diff_order),
        .diff_data_in  (diff_data_in),
        .diff_data_out (diff_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural differencing stage: one history value per difference level.
    logic [DW-1:0] hist_q [10];
    logic [DW-1:0] hist_d [10];
    logic [DW-1:0] out_d;

    always_comb begin
        logic [DW-1:0] v;
        v = diff_data_in;
        for (int i = 0; i < 10; i++) begin
            hist_d[i] = hist_q[i];
            if (i < int'(diff_order)) begin
                hist_d[i] = v;
                v = v - hist_q[i];
            end
        end
        out_d = v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) hist_q[i] <= '0;
            diff_data_out <= '0;
        end else if (diff_mode == 2'b11) begin
            for (int i = 0; i < 10; i++) hist_q[i] <= '0;
            diff_data_out <= '0;
        end else if (diff_mode == 2'b00) begin
            for (int i = 0; i < 10; i++) hist_q[i] <= hist_d[i];
            diff_data_out <= out_d;
        end
    end

    typedef struct packed {
        int               ord;
        int               len;
        int               vpct;
        int               rpct;
        int               stall_out;
        int               nexp;
        int               snap_at;
        logic [5:0][31:0] data;
        logic [5:0][31:0] expv;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   samples[$];
    int   got[$];
    int   snaps, snap_at, dones, accepts, clear_cnt, work_cnt;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic logic [5:0][31:0] pk6(input int a, input int b, input int c,
                                             input int d, input int e, input int f);
        logic [5:0][31:0] r;
        r[0] = 32'(a); r[1] = 32'(b); r[2] = 32'(c);
        r[3] = 32'(d); r[4] = 32'(e); r[5] = 32'(f);
        return r;
    endfunction

    function automatic vec_t mk(input int ord, input int len, input int vpct, input int rpct,
                                input int stall_out, input int nexp, input int snap_at,
                                input logic [5:0][31:0] data, input logic [5:0][31:0] expv);
        vec_t v;
        v.ord = ord; v.len = len; v.vpct = vpct; v.rpct = rpct;
        v.stall_out = stall_out; v.nexp = nexp; v.snap_at = snap_at;
        v.data = data; v.expv = expv;
        return v;
    endfunction

    // Runs one frame from IDLE to its done pulse and scores it against the
    // d-th difference computed directly from the accepted samples.
    task automatic run_frame(input int ord, input int len, input int vpct, input int rpct,
                             input int stall_out);
        int si, cyc, stall_left, prev_data, e, nexp;
        bit stall_used, prev_stall;
        int exp_q[$];
        si = 0; cyc = 0; stall_left = 0; prev_data = 0;
        stall_used = 1'b0; prev_stall = 1'b0;
        got.delete();
        snaps = 0; snap_at = -1; dones = 0; accepts = 0; clear_cnt = 0; work_cnt = 0;
        bus.start     = 1'b1;
        bus.cfg_order = 4'(ord);
        bus.cfg_len   = LW'(len);
        @(negedge clk);
        bus.cfg_order = 4'($urandom_range(15));
        bus.cfg_len   = LW'($urandom_range(50));
        while (dones == 0 && cyc < 1000) begin
            if (!stall_used && stall_out >= 0 && bus.m_valid && got.size() == stall_out) begin
                stall_left = 3;
                stall_used = 1'b1;
            end
            bus.start   = (cyc > 0) && ($urandom_range(3) == 0);
            bus.s_valid = (int'($urandom_range(99)) < vpct);
            bus.s_data  = (si < len) ? DW'(samples[si]) : DW'($urandom);
            bus.m_ready = (stall_left > 0) ? 1'b0 : (int'($urandom_range(99)) < rpct);
            #1;
            if (cyc == 0) check("clear_first", int'(diff_mode), 3);
            if (prev_stall && bus.m_valid) check("hold_data", int'(bus.m_data), prev_data);
            if (bus.m_valid && !bus.m_ready) check("stall_s_ready", int'(bus.s_ready), 0);
            if (bus.snap) begin snaps++; snap_at = accepts; end
            if (bus.done) dones++;
            if (diff_mode == 2'b11) clear_cnt++;
            if (diff_mode == 2'b00) work_cnt++;
            if (bus.m_valid && bus.m_ready) got.push_back(int'(bus.m_data));
            if (bus.s_valid && bus.s_ready) begin si++; accepts++; end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = int'(bus.m_data);
            if (stall_left > 0) stall_left--;
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        check("done_seen", dones, 1);
        check("accepts", accepts, len);
        for (int k = ord; k < len; k++) begin
            e = 0;
            for (int j = 0; j <= ord; j++)
                e += ((j % 2) ? -1 : 1) * binom(ord, j) * samples[k - j];
            exp_q.push_back(e);
        end
        nexp = exp_q.size();
        check("out_count", got.size(), nexp);
        for (int i = 0; i < nexp && i < got.size(); i++) check("out_data", got[i], exp_q[i]);
        check("snap_count", snaps, (ord >= 1 && len >= ord) ? 1 : 0);
        if (ord >= 1 && len >= ord) check("snap_at", snap_at, ord);
        check("clear_cycles", clear_cnt, 1);
        check("work_cycles", work_cnt, len);
    endtask

    task automatic load_squares();
        samples.delete();
        for (int i = 1; i <= 6; i++) samples.push_back(i * i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, dcnt, ord, len;
        vecs[0] = mk(2, 6, 100, 100, -1, 4,  2, pk6(1, 4, 9, 16, 25, 36), pk6(2, 2, 2, 2, 0, 0));
        vecs[1] = mk(2, 6, 100, 100,  1, 4,  2, pk6(1, 4, 9, 16, 25, 36), pk6(2, 2, 2, 2, 0, 0));
        vecs[2] = mk(0, 3, 100, 100, -1, 3, -1, pk6(7, -5, 3, 0, 0, 0),   pk6(7, -5, 3, 0, 0, 0));
        vecs[3] = mk(3, 3, 100, 100, -1, 0,  3, pk6(5, 1, 8, 0, 0, 0),    pk6(0, 0, 0, 0, 0, 0));
        vecs[4] = mk(1, 5, 100, 100, -1, 4,  1, pk6(10, 3, 3, -2, 100, 0), pk6(-7, 0, -5, 102, 0, 0));
        vecs[5] = mk(0, 0, 100, 100, -1, 0, -1, pk6(0, 0, 0, 0, 0, 0),    pk6(0, 0, 0, 0, 0, 0));
        vecs[6] = mk(2, 6,  60,  50, -1, 4,  2, pk6(1, 4, 9, 16, 25, 36), pk6(2, 2, 2, 2, 0, 0));
        vecs[7] = mk(9, 6, 100, 100, -1, 0, -1, pk6(1, 2, 3, 4, 5, 6),    pk6(0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_order = '0; bus.cfg_len = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_snap", int'(bus.snap), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_mode", int'(diff_mode), 1);
        check("rst_s_ready", int'(bus.s_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed frames.
        for (int v = 0; v < NV; v++) begin
            samples.delete();
            for (int i = 0; i < vecs[v].len && i < 6; i++) samples.push_back(int'(vecs[v].data[i]));
            run_frame(vecs[v].ord, vecs[v].len, vecs[v].vpct, vecs[v].rpct, vecs[v].stall_out);
            check("vec_count", got.size(), vecs[v].nexp);
            for (int i = 0; i < vecs[v].nexp; i++)
                check("vec_out", (i < got.size()) ? got[i] : 32'h7fff_ffff, int'(vecs[v].expv[i]));
            check("vec_snap_at", snap_at, vecs[v].snap_at);
        end

        // Abort where the 4th accept would land, then a clean restart.
        load_squares();
        bus.start = 1'b1; bus.cfg_order = 4'd2; bus.cfg_len = LW'(6);
        @(negedge clk);
        bus.start = 1'b0; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            bus.s_data = DW'(samples[acc]);
            #1;
            if (bus.s_valid && bus.s_ready) acc++;
            @(negedge clk);
        end
        check("pre_abort_acc", acc, 3);
        bus.abort = 1'b1; bus.s_data = DW'(samples[3]);
        #1;
        check("abort_mode", int'(diff_mode), 3);
        check("abort_s_ready", int'(bus.s_ready), 0);
        @(negedge clk);
        bus.abort = 1'b0; bus.s_valid = 1'b0;
        #1;
        check("abort_m_valid", int'(bus.m_valid), 0);
        check("abort_busy", int'(bus.busy), 0);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.done) dcnt++;
            @(negedge clk);
            #1;
        end
        check("abort_no_done", dcnt, 0);
        @(negedge clk);
        load_squares();
        run_frame(2, 6, 100, 100, -1);

        // Abort while idle only clears the stage for that cycle.
        bus.abort = 1'b1;
        #1;
        check("idle_abort_mode", int'(diff_mode), 3);
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        check("idle_abort_after", int'(diff_mode), 1);
        check("idle_abort_busy", int'(bus.busy), 0);
        @(negedge clk);

        // Illegal order, legal restart, then reset in the middle of a frame.
        bus.start = 1'b1; bus.cfg_order = 4'd12; bus.cfg_len = LW'(5);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("cfg_err_set", int'(bus.cfg_err), 1);
        check("cfg_err_busy", int'(bus.busy), 0);
        @(negedge clk);
        #1;
        check("cfg_err_sticky", int'(bus.cfg_err), 1);
        check("cfg_err_idle", int'(bus.busy), 0);
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_order = 4'd1; bus.cfg_len = LW'(8);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("cfg_err_clear", int'(bus.cfg_err), 0);
        check("legal_busy", int'(bus.busy), 1);
        bus.s_valid = 1'b1; bus.s_data = DW'(17); bus.m_ready = 1'b0;
        for (int c = 0; c < 4; c++) @(negedge clk);
        #1;
        check("pre_rst_m_valid", int'(bus.m_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", int'(bus.m_valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_snap", int'(bus.snap), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_cfg_err", int'(bus.cfg_err), 0);
        check("mid_rst_mode", int'(diff_mode), 1);
        check("mid_rst_s_ready", int'(bus.s_ready), 0);
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_squares();
        run_frame(2, 6, 100, 100, -1);

        // Random frames against the reference.
        for (int f = 0; f < 25; f++) begin
            ord = int'($urandom_range(9));
            len = int'($urandom_range(16));
            samples.delete();
            for (int i = 0; i < len; i++) samples.push_back(int'($urandom_range(2000)) - 1000);
            run_frame(ord, len, 30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)),
                      ($urandom_range(1) == 0) ? -1 : int'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
